axi_wr_burst_slave: RTL

AXI_WR_BURST_SLAVE -- requirements
Module: axi_wr_burst_slave

---
 rtl/axi_wr_burst_slave_pkg.sv | 24 ++
 rtl/axi_wr_burst_slave_fifo.sv | 45 ++++
 rtl/axi_wr_burst_slave.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/axi_wr_burst_slave_pkg.sv
// Shared AXI definitions for the write-burst slave: burst and response codes,
// the FSM state encoding and a WRAP length legality helper.
package axi_wr_burst_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } wr_state_e;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_wr_burst_slave_fifo.sv
// Synchronous FIFO with registered storage; a push is accepted while full
// provided a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/axi_wr_burst_slave.sv
// AXI write-burst slave: accepts one burst at a time, buffers beats with their
// computed addresses and drains them to a simple valid/ready write port.
module axi_wr_burst_slave
    import axi_wr_burst_slave_pkg::*;
#(
    parameter int                ID_WIDTH   = 8,
    parameter int                ADDR_WIDTH = 11,
    parameter int                DATA_WIDTH = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ID_WIDTH-1:0] SLAVE_ID = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic                    wr_vld,
    input  logic                    wr_rdy,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    wr_last,
    input  logic                    wr_err,
    output logic                    busy
);

    localparam int         STRB_WIDTH = DATA_WIDTH / 8;
    localparam int         ENTRY_W    = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH + 1;
    localparam logic [2:0] MAX_SIZE   = 3'($clog2(STRB_WIDTH));

    wr_state_e             state;
    wr_state_e             state_nxt;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [7:0]            aw_len_q;
    logic [2:0]            aw_size_q;
    logic [1:0]            aw_burst_q;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [7:0]            beat_cnt;
    logic                  w_done;
    logic                  err_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  pop;
    logic                  beat_last;
    logic                  aw_bad;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_in;
    logic [ENTRY_W-1:0]    fifo_out;

    logic [31:0]           wrap_bytes;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    assign aw_hs     = (state == ST_IDLE) && AWVALID && (AWID == SLAVE_ID);
    assign w_hs      = WVALID & WREADY;
    assign pop       = wr_vld & wr_rdy;
    assign beat_last = (beat_cnt == aw_len_q);
    assign aw_bad    = (AWBURST == BURST_RSVD)
                     || ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN))
                     || (AWSIZE > MAX_SIZE);

    // WRAP keeps the bits above the window and lets only the offset roll over.
    assign wrap_bytes = ({24'd0, aw_len_q} + 32'd1) << aw_size_q;
    assign wrap_mask  = ADDR_WIDTH'(wrap_bytes - 32'd1);
    assign addr_inc   = cur_addr + (ADDR_WIDTH'(1) << aw_size_q);

    always_comb begin
        addr_nxt = addr_inc;
        case (aw_burst_q)
            BURST_FIXED: addr_nxt = cur_addr;
            BURST_WRAP:  addr_nxt = (cur_addr & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_nxt = addr_inc;
        endcase
    end

    always_comb begin
        state_nxt = state;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BID       = '0;
        BRESP     = RESP_OKAY;
        case (state)
            ST_IDLE: begin
                AWREADY = 1'b1;
                if (aw_hs) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                WREADY = ~fifo_full & ~w_done;
                if (pop && wr_last) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                BVALID = 1'b1;
                BID    = aw_id_q;
                BRESP  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (BREADY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            w_done   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (aw_hs) begin
                beat_cnt <= '0;
                w_done   <= 1'b0;
                err_q    <= aw_bad;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 8'd1;
                w_done   <= beat_last;
                if (WLAST != beat_last) err_q <= 1'b1;
            end
            if (pop && wr_err) err_q <= 1'b1;
            if (BVALID && BREADY) err_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_id_q    <= AWID;
            aw_len_q   <= AWLEN;
            aw_size_q  <= AWSIZE;
            aw_burst_q <= AWBURST;
            cur_addr   <= AWADDR;
        end else if (w_hs) begin
            cur_addr <= addr_nxt;
        end
    end

    assign fifo_in = {cur_addr, WDATA, WSTRB, beat_last};
    assign wr_vld  = ~fifo_empty;
    assign {wr_addr, wr_data, wr_strb, wr_last} = fifo_out;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_hs),
        .push_data (fifo_in),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
